// File: rtl/instruction_fetch.sv
// Fetch stage in front of a synchronous instruction memory: issues addresses,
// pairs each returned word with its address, and handles stall, redirect and start/done.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32,
  parameter int RESET_PC   = 0,
  parameter int LAST_PC    = 23,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_pc,
  input  logic [WORD_WIDTH-1:0] imem_data,
  output logic                  if_valid,
  output logic [WORD_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] LastPc  = ADDR_WIDTH'(LAST_PC);
  localparam logic [ADDR_WIDTH-1:0] PcOne   = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept;

  // A word presented while a redirect is taken belongs to the wrong path, so it is squashed.
  assign if_valid    = (state_q == RUN) & valid_q & ~redirect;
  assign accept      = if_valid & ~stall;
  assign if_instr    = imem_data;
  assign if_pc       = if_pc_q;
  assign done        = (state_q == DONE);
  assign fetch_count = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    imem_pc = ResetPc;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          if_pc_d = ResetPc;
          pc_d    = ResetPc + PcOne;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (redirect) begin
          imem_pc = redirect_pc;
          if_pc_d = redirect_pc;
          pc_d    = redirect_pc + PcOne;
          valid_d = 1'b1;
        end else if (stall && valid_q) begin
          // Re-read the held address so imem_data keeps presenting the same word.
          imem_pc = if_pc_q;
        end else begin
          imem_pc = pc_q;
          if_pc_d = pc_q;
          pc_d    = pc_q + PcOne;
          valid_d = 1'b1;
        end

        if (accept) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CntOne;
          end
          if (if_pc_q == LastPc) begin
            state_d = DONE;
            valid_d = 1'b0;
            pc_d    = ResetPc;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ResetPc;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous memory model plus a program-level
// reference (current address, running/done, count) checked every cycle.
module tb_instruction_fetch;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int CW = 16;
  localparam logic [WW-1:0] Word0 = 32'h28011DD0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall, redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_pc;
  logic [WW-1:0] imem_data;
  logic          if_valid;
  logic [WW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          done;
  logic [CW-1:0] fetch_count;

  logic [WW-1:0] mem [0:1023];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the address being presented, program phase, accepted count.
  logic          mRun, mDone;
  logic [AW-1:0] mCur;
  logic [CW-1:0] mCount;

  logic          capValid, capDone;
  logic [AW-1:0] capPc;
  logic [WW-1:0] capInstr;
  logic [CW-1:0] capCount;

  instruction_fetch #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RESET_PC(0), .LAST_PC(23), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_pc(imem_pc), .imem_data(imem_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .done(done),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_pc];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mRun = 1'b0; mDone = 1'b0; mCur = '0; mCount = '0;
  endtask

  // Compare the live outputs against the reference for the inputs now applied.
  task automatic checkOutput();
    logic          expValid;
    logic [AW-1:0] expImem;
    expValid = mRun & ~redirect;
    if (!mRun)         expImem = '0;
    else if (redirect) expImem = redirect_pc;
    else if (stall)    expImem = mCur;
    else               expImem = mCur + AW'(1);
    capValid = if_valid; capDone = done; capPc = if_pc;
    capInstr = if_instr; capCount = fetch_count;
    checkValue("if_valid", {31'd0, if_valid}, {31'd0, expValid});
    checkValue("done", {31'd0, done}, {31'd0, mDone});
    checkValue("fetch_count", {16'd0, fetch_count}, {16'd0, mCount});
    checkValue("imem_pc", {22'd0, imem_pc}, {22'd0, expImem});
    if (expValid) begin
      checkValue("if_pc", {22'd0, if_pc}, {22'd0, mCur});
      checkValue("if_instr", if_instr, mem[mCur]);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the reference.
  task automatic applyStimulus(input logic st, input logic sl, input logic rd,
                               input logic [AW-1:0] rpc);
    @(negedge clk);
    start = st; stall = sl; redirect = rd; redirect_pc = rpc;
    #1;
    checkOutput();
    @(posedge clk);
    if (!mRun) begin
      if (st) begin
        mRun = 1'b1; mDone = 1'b0; mCur = '0; mCount = '0;
      end
    end else if (rd) begin
      mCur = rpc;
    end else if (!sl) begin
      if (mCount != '1) mCount = mCount + 1'b1;
      if (mCur == AW'(23)) begin
        mRun = 1'b0; mDone = 1'b1;
      end else begin
        mCur = mCur + AW'(1);
      end
    end
  endtask

  task automatic runToDone();
    for (int i = 0; i < 64 && !mDone; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("doneReached", {31'd0, mDone}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = Word0;
    mem[8] = Word0;
    start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    modelReset();
    #12;
    checkValue("rstValid", {31'd0, if_valid}, 32'd0);
    checkValue("rstDone", {31'd0, done}, 32'd0);
    checkValue("rstCount", {16'd0, fetch_count}, 32'd0);
    checkValue("rstImemPc", {22'd0, imem_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Start, first word, then sequential stepping.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("firstValid", {31'd0, capValid}, 32'd1);
    checkValue("firstPc", {22'd0, capPc}, 32'd0);
    checkValue("firstInstr", capInstr, Word0);
    for (int p = 1; p < 4; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkValue("seqPc", {22'd0, capPc}, p);
    end

    // Stall three cycles on pc 4.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkValue("stallPc", {22'd0, capPc}, 32'd4);
      checkValue("stallInstr", capInstr, mem[4]);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("afterStallPc", {22'd0, capPc}, 32'd5);
    checkValue("afterStallCount", {16'd0, capCount}, 32'd5);

    // Redirect beats stall; target word follows next cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(8));
    checkValue("redirSquash", {31'd0, capValid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("redirPc", {22'd0, capPc}, 32'd8);
    checkValue("redirInstr", capInstr, Word0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("redirNext", {22'd0, capPc}, 32'd9);
    runToDone();

    // Clean program from DONE: 24 words, then restart.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    runToDone();
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(5));
    checkValue("doneFlag", {31'd0, capDone}, 32'd1);
    checkValue("doneCount", {16'd0, capCount}, 32'd24);
    checkValue("doneValid", {31'd0, capValid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("restartPc", {22'd0, capPc}, 32'd0);
    checkValue("restartDone", {31'd0, capDone}, 32'd0);

    // Address wrap through 1023.
    applyStimulus(1'b0, 1'b0, 1'b1, AW'(1023));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("wrapTop", {22'd0, capPc}, 32'd1023);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("wrapZero", {22'd0, capPc}, 32'd0);
    runToDone();

    // Asynchronous reset in the middle of a stalled run.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20 && mCur != AW'(6); i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("asyncValid", {31'd0, if_valid}, 32'd0);
    checkValue("asyncDone", {31'd0, done}, 32'd0);
    checkValue("asyncCount", {16'd0, fetch_count}, 32'd0);
    checkValue("asyncImemPc", {22'd0, imem_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("postResetPc", {22'd0, capPc}, 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 30)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
